spi_minion_adapter_multi: RTL and testbench

SPI_MINION_ADAPTER_MULTI -- requirements
Module: spi_minion_adapter_multi

---
 rtl/spi_adapter_pkg.sv | 13 +
 rtl/spi_adapter_channel.sv | 81 ++++++++
 rtl/vc_queue.sv | 56 +++++
 rtl/spi_minion_adapter_multi.sv | 116 +++++++++++
 tb/tb_spi_minion_adapter_multi.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_adapter_pkg.sv
// Shared definitions for the multi-channel SPI minion adapter: channel-address
// width helper and per-channel error-flag bit positions.
package spi_adapter_pkg;

  localparam int ERR_OVF_IDX = 0;
  localparam int ERR_UNF_IDX = 1;
  localparam int ERR_NUM     = 2;

  function automatic int cw_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_adapter_channel.sv
// One adapter channel: minion->channel (mc) and channel->minion (cm) queues with
// sticky overflow/underflow flags. Optional parity via SPI_ADAPTER_PARITY_EN.
module spi_adapter_channel import spi_adapter_pkg::*; #(
  parameter int nbits       = 8,
  parameter int num_entries = 2,
  localparam int PW = nbits - 2,
  localparam int FW = $clog2(num_entries + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr_en,
  input  logic [PW-1:0] i_wr_msg,
  input  logic          i_rd_en,
  input  logic          i_err_clr,
  output logic          o_mc_rdy,
  output logic [FW-1:0] o_mc_free,
  output logic          o_cm_val,
  output logic [PW-1:0] o_cm_msg,
  input  logic [PW-1:0] i_recv_msg,
  input  logic          i_recv_val,
  output logic          o_recv_rdy,
  output logic [PW-1:0] o_send_msg,
  output logic          o_send_val,
  input  logic          i_send_rdy,
  output logic          o_parity,
  output logic          o_err_ovf,
  output logic          o_err_unf
);

  logic               w_mc_val;
  logic [FW-1:0]      w_cm_free;
  logic               w_cm_val;
  logic [ERR_NUM-1:0] w_err_set;
  logic [ERR_NUM-1:0] r_err;

  vc_Queue #(.p_msg_nbits(PW), .p_num_msgs(num_entries)) u_mc (
    .clk              (clk),
    .reset            (reset),
    .recv_val         (i_wr_en),
    .recv_msg         (i_wr_msg),
    .send_val         (w_mc_val),
    .send_rdy         (i_send_rdy),
    .send_msg         (o_send_msg),
    .num_free_entries (o_mc_free)
  );

  vc_Queue #(.p_msg_nbits(PW), .p_num_msgs(num_entries)) u_cm (
    .clk              (clk),
    .reset            (reset),
    .recv_val         (i_recv_val),
    .recv_msg         (i_recv_msg),
    .send_val         (w_cm_val),
    .send_rdy         (i_rd_en),
    .send_msg         (o_cm_msg),
    .num_free_entries (w_cm_free)
  );

  // Valids are masked while reset is held so nothing stale leaks out
  assign o_mc_rdy   = (o_mc_free != '0);
  assign o_recv_rdy = (w_cm_free != '0);
  assign o_send_val = w_mc_val & ~reset;
  assign o_cm_val   = w_cm_val & ~reset;

  assign w_err_set[ERR_OVF_IDX] = i_wr_en & ~o_mc_rdy;
  assign w_err_set[ERR_UNF_IDX] = i_rd_en & ~w_cm_val;
  assign o_err_ovf = r_err[ERR_OVF_IDX];
  assign o_err_unf = r_err[ERR_UNF_IDX];

  // Sticky error flags; a new event outranks a coincident clear
  always_ff @(posedge clk) begin
    if (reset) r_err <= '0;
    else       r_err <= w_err_set | (i_err_clr ? '0 : r_err);
  end

`ifdef SPI_ADAPTER_PARITY_EN
  assign o_parity = (^o_send_msg) & o_send_val;
`else
  assign o_parity = 1'b0;
`endif

endmodule

// File: rtl/vc_queue.sv
// Normal (non-bypass) val/rdy FIFO; readiness is exported as num_free_entries
// so a wrapper can derive both recv_rdy and look-ahead space from one value.
module vc_Queue #(
  parameter int p_msg_nbits = 8,
  parameter int p_num_msgs  = 2,
  localparam int AW   = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1,
  localparam int CNTW = $clog2(p_num_msgs + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   recv_val,
  input  logic [p_msg_nbits-1:0] recv_msg,
  output logic                   send_val,
  input  logic                   send_rdy,
  output logic [p_msg_nbits-1:0] send_msg,
  output logic [CNTW-1:0]        num_free_entries
);

  logic [p_msg_nbits-1:0] r_mem [p_num_msgs];
  logic [AW-1:0]          r_head;
  logic [AW-1:0]          r_tail;
  logic [CNTW-1:0]        r_count;
  logic                   w_enq;
  logic                   w_deq;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(p_num_msgs - 1)) ? '0 : p + AW'(1);
  endfunction

  assign num_free_entries = CNTW'(p_num_msgs) - r_count;
  assign send_val         = (r_count != '0);
  assign send_msg         = r_mem[r_head];
  assign w_enq            = recv_val & (r_count != CNTW'(p_num_msgs));
  assign w_deq            = send_val & send_rdy;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= ptr_next(r_tail);
      if (w_deq) r_head <= ptr_next(r_head);
      if (w_enq && !w_deq)      r_count <= r_count + CNTW'(1);
      else if (!w_enq && w_deq) r_count <= r_count - CNTW'(1);
      else                      r_count <= r_count;
    end
  end

  // Storage write port
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_tail] <= recv_msg;
  end

endmodule

// File: rtl/spi_minion_adapter_multi.sv
// Multi-channel SPI minion adapter: routes minion writes/reads to per-channel
// queue pairs by address. Parity output enabled by SPI_ADAPTER_PARITY_EN.
module spi_minion_adapter_multi import spi_adapter_pkg::*; #(
  parameter int nbits       = 8,
  parameter int num_entries = 2,
  parameter int num_chan    = 4,
  localparam int CW = cw_width(num_chan),
  localparam int PW = nbits - 2,
  localparam int FW = $clog2(num_entries + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pull_en,
  output logic                         pull_msg_val,
  output logic                         pull_msg_spc,
  output logic [PW-1:0]                pull_msg_data,
  input  logic                         push_en,
  input  logic                         push_msg_val_wrt,
  input  logic                         push_msg_val_rd,
  input  logic [nbits-1:0]             push_msg_data,
  input  logic [CW-1:0]                push_msg_addr,
  input  logic [num_chan-1:0][PW-1:0]  recv_msg,
  input  logic [num_chan-1:0]          recv_val,
  output logic [num_chan-1:0]          recv_rdy,
  output logic [num_chan-1:0][PW-1:0]  send_msg,
  output logic [num_chan-1:0]          send_val,
  input  logic [num_chan-1:0]          send_rdy,
  output logic [num_chan-1:0]          parity,
  input  logic                         err_clr,
  output logic [num_chan-1:0]          err_ovf,
  output logic [num_chan-1:0]          err_unf,
  output logic                         err_addr
);

  logic                        w_wr;
  logic                        w_rd;
  logic                        w_addr_ok;
  logic                        w_bad;
  logic [num_chan-1:0]         w_hit;
  logic [num_chan-1:0]         w_mc_rdy;
  logic [num_chan-1:0][FW-1:0] w_mc_free;
  logic [num_chan-1:0]         w_cm_val;
  logic [num_chan-1:0][PW-1:0] w_cm_msg;
  logic                        w_sel_mc_rdy;
  logic [FW-1:0]               w_sel_mc_free;
  logic                        w_sel_cm_val;
  logic [PW-1:0]               w_sel_cm_msg;
  logic [1:0]                  w_unused_hdr;
  logic                        r_err_addr;

  // Top two packet bits are framing owned by the SPI layer
  assign w_unused_hdr = push_msg_data[nbits-1:nbits-2];

  assign w_wr      = push_en & push_msg_val_wrt;
  assign w_rd      = pull_en & push_msg_val_rd;
  assign w_addr_ok = (int'(push_msg_addr) < num_chan);
  assign w_bad     = (w_wr | w_rd) & ~w_addr_ok;

  genvar gi;
  generate
    for (gi = 0; gi < num_chan; gi++) begin : g_chan
      assign w_hit[gi] = w_addr_ok & (push_msg_addr == CW'(gi));

      spi_adapter_channel #(.nbits(nbits), .num_entries(num_entries)) u_chan (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (w_wr & w_hit[gi]),
        .i_wr_msg   (push_msg_data[PW-1:0]),
        .i_rd_en    (w_rd & w_hit[gi]),
        .i_err_clr  (err_clr),
        .o_mc_rdy   (w_mc_rdy[gi]),
        .o_mc_free  (w_mc_free[gi]),
        .o_cm_val   (w_cm_val[gi]),
        .o_cm_msg   (w_cm_msg[gi]),
        .i_recv_msg (recv_msg[gi]),
        .i_recv_val (recv_val[gi]),
        .o_recv_rdy (recv_rdy[gi]),
        .o_send_msg (send_msg[gi]),
        .o_send_val (send_val[gi]),
        .i_send_rdy (send_rdy[gi]),
        .o_parity   (parity[gi]),
        .o_err_ovf  (err_ovf[gi]),
        .o_err_unf  (err_unf[gi])
      );
    end
  endgenerate

  // One-hot AND-OR select of the addressed channel's status
  always_comb begin
    w_sel_mc_rdy  = 1'b0;
    w_sel_mc_free = '0;
    w_sel_cm_val  = 1'b0;
    w_sel_cm_msg  = '0;
    for (int i = 0; i < num_chan; i++) begin
      w_sel_mc_rdy  = w_sel_mc_rdy | (w_hit[i] & w_mc_rdy[i]);
      w_sel_mc_free = w_sel_mc_free | ({FW{w_hit[i]}} & w_mc_free[i]);
      w_sel_cm_val  = w_sel_cm_val | (w_hit[i] & w_cm_val[i]);
      w_sel_cm_msg  = w_sel_cm_msg | ({PW{w_hit[i]}} & w_cm_msg[i]);
    end
  end

  // Space is advertised only if the slot survives this cycle's write
  assign pull_msg_spc  = w_addr_ok & w_sel_mc_rdy & (~w_wr | (w_sel_mc_free > FW'(1)));
  assign pull_msg_val  = w_rd & w_sel_cm_val;
  assign pull_msg_data = pull_msg_val ? w_sel_cm_msg : '0;
  assign err_addr      = r_err_addr;

  // Sticky bad-address flag; set outranks clear
  always_ff @(posedge clk) begin
    if (reset)        r_err_addr <= 1'b0;
    else if (w_bad)   r_err_addr <= 1'b1;
    else if (err_clr) r_err_addr <= 1'b0;
    else              r_err_addr <= r_err_addr;
  end

endmodule

// File: tb/tb_spi_minion_adapter_multi.sv
// Scoreboard bench for spi_minion_adapter_multi: a 4-channel instance for the
// data paths and a 3-channel instance for out-of-range addressing.
module tb_spi_minion_adapter_multi;

  localparam int NC = 4;
  localparam int NB = 8;
  localparam int PW = NB - 2;
`ifdef SPI_ADAPTER_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic pull_en, pull_msg_val, pull_msg_spc;
  logic [PW-1:0] pull_msg_data;
  logic push_en, push_msg_val_wrt, push_msg_val_rd;
  logic [NB-1:0] push_msg_data;
  logic [1:0] push_msg_addr;
  logic [NC-1:0][PW-1:0] recv_msg, send_msg;
  logic [NC-1:0] recv_val, recv_rdy, send_val, send_rdy, parity, err_ovf, err_unf;
  logic err_clr, err_addr;

  logic b_pull_en, b_pull_msg_val, b_pull_msg_spc;
  logic [PW-1:0] b_pull_msg_data;
  logic b_push_en, b_push_msg_val_wrt, b_push_msg_val_rd;
  logic [NB-1:0] b_push_msg_data;
  logic [1:0] b_push_msg_addr;
  logic [2:0][PW-1:0] b_recv_msg, b_send_msg;
  logic [2:0] b_recv_val, b_recv_rdy, b_send_val, b_send_rdy, b_parity, b_err_ovf, b_err_unf;
  logic b_err_clr, b_err_addr;

  int n_chk = 0;
  int n_fail = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] pull_q[$];
  logic [PW-1:0] exp_v;

  always #5 clk = ~clk;

  spi_minion_adapter_multi #(.nbits(NB), .num_entries(2), .num_chan(NC)) u_dut (
    .clk(clk), .reset(reset), .pull_en(pull_en), .pull_msg_val(pull_msg_val),
    .pull_msg_spc(pull_msg_spc), .pull_msg_data(pull_msg_data), .push_en(push_en),
    .push_msg_val_wrt(push_msg_val_wrt), .push_msg_val_rd(push_msg_val_rd),
    .push_msg_data(push_msg_data), .push_msg_addr(push_msg_addr), .recv_msg(recv_msg),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .send_msg(send_msg), .send_val(send_val),
    .send_rdy(send_rdy), .parity(parity), .err_clr(err_clr), .err_ovf(err_ovf),
    .err_unf(err_unf), .err_addr(err_addr)
  );

  spi_minion_adapter_multi #(.nbits(NB), .num_entries(2), .num_chan(3)) u_dut3 (
    .clk(clk), .reset(reset), .pull_en(b_pull_en), .pull_msg_val(b_pull_msg_val),
    .pull_msg_spc(b_pull_msg_spc), .pull_msg_data(b_pull_msg_data), .push_en(b_push_en),
    .push_msg_val_wrt(b_push_msg_val_wrt), .push_msg_val_rd(b_push_msg_val_rd),
    .push_msg_data(b_push_msg_data), .push_msg_addr(b_push_msg_addr), .recv_msg(b_recv_msg),
    .recv_val(b_recv_val), .recv_rdy(b_recv_rdy), .send_msg(b_send_msg), .send_val(b_send_val),
    .send_rdy(b_send_rdy), .parity(b_parity), .err_clr(b_err_clr), .err_ovf(b_err_ovf),
    .err_unf(b_err_unf), .err_addr(b_err_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pull_en = 1'b0; push_en = 1'b0; push_msg_val_wrt = 1'b0; push_msg_val_rd = 1'b0;
    push_msg_data = '0; push_msg_addr = '0; recv_val = '0; recv_msg = '0; err_clr = 1'b0;
    b_pull_en = 1'b0; b_push_en = 1'b0; b_push_msg_val_wrt = 1'b0; b_push_msg_val_rd = 1'b0;
    b_push_msg_data = '0; b_push_msg_addr = '0; b_recv_val = '0; b_recv_msg = '0;
    b_err_clr = 1'b0; b_send_rdy = '0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [PW-1:0] d);
    push_en = 1'b1; push_msg_val_wrt = 1'b1; push_msg_addr = a; push_msg_data = {2'b01, d};
  endtask

  task automatic do_read(input logic [1:0] a);
    pull_en = 1'b1; push_msg_val_rd = 1'b1; push_msg_addr = a;
  endtask

  task automatic drain_ch(input int ch);
    send_rdy[ch] = 1'b1;
    repeat (3) tick();
    send_rdy[ch] = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle(); send_rdy = '0; reset = 1'b1;
    tick(); tick();
    n_chk++; if (send_val !== '0 || pull_msg_val !== 1'b0 || pull_msg_data !== '0 || parity !== '0) begin
      n_fail++; $display("FAIL reset_outputs: send_val=%b pull_val=%b data=%h parity=%b want 0", send_val, pull_msg_val, pull_msg_data, parity); end
    n_chk++; if (err_ovf !== '0 || err_unf !== '0 || err_addr !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: ovf=%b unf=%b addr=%b want 0", err_ovf, err_unf, err_addr); end
    reset = 1'b0; tick();
    n_chk++; if (recv_rdy !== 4'hF) begin
      n_fail++; $display("FAIL reset_recv_rdy: got %b want 1111", recv_rdy); end
  endtask

  task automatic test_write();
    do_write(2'd2, 6'h15); exp_q.push_back(6'h15); #1;
    n_chk++; if (pull_msg_spc !== 1'b1) begin
      n_fail++; $display("FAIL write_spc: got %b want 1", pull_msg_spc); end
    tick(); idle();
    n_chk++; if (send_val !== 4'b0100) begin
      n_fail++; $display("FAIL write_send_val: got %b want 0100", send_val); end
    exp_v = exp_q.pop_front();
    n_chk++; if (send_msg[2] !== exp_v) begin
      n_fail++; $display("FAIL write_send_msg: got %h want %h", send_msg[2], exp_v); end
    drain_ch(2);
    n_chk++; if (send_val !== '0) begin
      n_fail++; $display("FAIL write_drained: got %b want 0000", send_val); end
  endtask

  task automatic test_overflow();
    logic [2:0] exp_spc;
    exp_spc = 3'b001;
    for (int k = 0; k < 3; k++) begin
      do_write(2'd1, 6'h31 + 6'(k));
      if (k < 2) exp_q.push_back(6'h31 + 6'(k));
      #1;
      n_chk++; if (pull_msg_spc !== exp_spc[k]) begin
        n_fail++; $display("FAIL ovf_spc%0d: got %b want %b", k, pull_msg_spc, exp_spc[k]); end
      tick();
    end
    idle(); #1;
    n_chk++; if (err_ovf !== 4'b0010) begin
      n_fail++; $display("FAIL ovf_flag: got %b want 0010", err_ovf); end
    send_rdy[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (send_val[1] === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL ovf_extra: got %h want nothing", send_msg[1]); end
        else begin
          exp_v = exp_q.pop_front();
          if (send_msg[1] !== exp_v) begin
            n_fail++; $display("FAIL ovf_order: got %h want %h", send_msg[1], exp_v); end
        end
      end
      tick();
    end
    send_rdy[1] = 1'b0;
    n_chk++; if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL ovf_missing: %0d entries never delivered want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_read();
    recv_val[3] = 1'b1; recv_msg[3] = 6'h2A; pull_q.push_back(6'h2A); #1;
    n_chk++; if (recv_rdy[3] !== 1'b1) begin
      n_fail++; $display("FAIL read_recv_rdy: got %b want 1", recv_rdy[3]); end
    tick(); idle();
    do_read(2'd3); #1;
    exp_v = pull_q.pop_front();
    n_chk++; if (pull_msg_val !== 1'b1 || pull_msg_data !== exp_v) begin
      n_fail++; $display("FAIL read_data: val=%b data=%h want 1/%h", pull_msg_val, pull_msg_data, exp_v); end
    tick(); #1;
    n_chk++; if (pull_msg_val !== 1'b0 || pull_msg_data !== '0) begin
      n_fail++; $display("FAIL read_empty: val=%b data=%h want 0/00", pull_msg_val, pull_msg_data); end
    tick(); idle(); #1;
    n_chk++; if (err_unf !== 4'b1000) begin
      n_fail++; $display("FAIL read_unf: got %b want 1000", err_unf); end
    err_clr = 1'b1; tick(); idle();
    n_chk++; if (err_unf !== '0 || err_ovf !== '0) begin
      n_fail++; $display("FAIL err_clr: ovf=%b unf=%b want 0", err_ovf, err_unf); end
  endtask

  task automatic test_same_cycle();
    recv_val[0] = 1'b1; recv_msg[0] = 6'h11; pull_q.push_back(6'h11);
    tick(); idle();
    do_write(2'd0, 6'h22); do_read(2'd0); exp_q.push_back(6'h22); #1;
    exp_v = pull_q.pop_front();
    n_chk++; if (pull_msg_val !== 1'b1 || pull_msg_data !== exp_v) begin
      n_fail++; $display("FAIL same_read: val=%b data=%h want 1/%h", pull_msg_val, pull_msg_data, exp_v); end
    tick(); idle(); #1;
    exp_v = exp_q.pop_front();
    n_chk++; if (send_val[0] !== 1'b1 || send_msg[0] !== exp_v || err_unf !== '0) begin
      n_fail++; $display("FAIL same_write: val=%b msg=%h unf=%b want 1/%h/0", send_val[0], send_msg[0], err_unf, exp_v); end
    drain_ch(0);
  endtask

  task automatic test_independent();
    do_write(2'd1, 6'h01); tick(); do_write(2'd1, 6'h02); tick();
    do_write(2'd0, 6'h3C); #1;
    n_chk++; if (pull_msg_spc !== 1'b1) begin
      n_fail++; $display("FAIL indep_spc: got %b want 1", pull_msg_spc); end
    tick(); idle(); #1;
    n_chk++; if (send_val !== 4'b0011 || send_msg[0] !== 6'h3C) begin
      n_fail++; $display("FAIL indep_send: val=%b msg=%h want 0011/3c", send_val, send_msg[0]); end
    drain_ch(0); drain_ch(1);
  endtask

  task automatic test_parity();
    do_write(2'd0, 6'h07); tick(); idle(); #1;
    n_chk++; if (parity[0] !== PAR_ON) begin
      n_fail++; $display("FAIL parity_07: got %b want %b", parity[0], PAR_ON); end
    drain_ch(0);
    do_write(2'd0, 6'h03); tick(); idle(); #1;
    n_chk++; if (parity !== '0) begin
      n_fail++; $display("FAIL parity_03: got %b want 0000", parity); end
    drain_ch(0);
  endtask

  task automatic test_bad_addr();
    b_push_en = 1'b1; b_push_msg_val_wrt = 1'b1; b_push_msg_addr = 2'd3; b_push_msg_data = 8'h55;
    #1;
    n_chk++; if (b_pull_msg_spc !== 1'b0) begin
      n_fail++; $display("FAIL bad_spc: got %b want 0", b_pull_msg_spc); end
    tick(); idle(); #1;
    n_chk++; if (b_err_addr !== 1'b1 || b_send_val !== '0 || b_err_ovf !== '0) begin
      n_fail++; $display("FAIL bad_addr: addr=%b sv=%b ovf=%b want 1/000/000", b_err_addr, b_send_val, b_err_ovf); end
    b_err_clr = 1'b1; b_pull_en = 1'b1; b_push_msg_val_rd = 1'b1; b_push_msg_addr = 2'd3;
    tick(); idle(); #1;
    n_chk++; if (b_err_addr !== 1'b1 || b_err_unf !== '0) begin
      n_fail++; $display("FAIL bad_set_wins: addr=%b unf=%b want 1/000", b_err_addr, b_err_unf); end
    b_err_clr = 1'b1; tick(); idle();
    n_chk++; if (b_err_addr !== 1'b0) begin
      n_fail++; $display("FAIL bad_clear: got %b want 0", b_err_addr); end
  endtask

  task automatic test_reset_mid();
    for (int a = 0; a < NC; a++) begin
      do_write(2'(a), 6'(a + 8)); tick();
    end
    for (int k = 0; k < 2; k++) begin
      do_write(2'd1, 6'h3F); tick();
    end
    idle(); recv_val = 4'hF; recv_msg = {6'h21, 6'h22, 6'h23, 6'h24}; tick(); idle(); #1;
    n_chk++; if (err_ovf !== 4'b0010) begin
      n_fail++; $display("FAIL mid_pre_ovf: got %b want 0010", err_ovf); end
    reset = 1'b1; do_read(2'd0); #1;
    n_chk++; if (send_val !== '0 || pull_msg_val !== 1'b0 || pull_msg_data !== '0) begin
      n_fail++; $display("FAIL mid_in_reset: sv=%b pv=%b data=%h want 0", send_val, pull_msg_val, pull_msg_data); end
    tick(); idle(); reset = 1'b0; #1;
    n_chk++; if (send_val !== '0 || err_ovf !== '0 || err_unf !== '0 || err_addr !== 1'b0) begin
      n_fail++; $display("FAIL mid_after: sv=%b ovf=%b unf=%b addr=%b want 0", send_val, err_ovf, err_unf, err_addr); end
    do_read(2'd0); #1;
    n_chk++; if (pull_msg_val !== 1'b0) begin
      n_fail++; $display("FAIL mid_read_val: got %b want 0", pull_msg_val); end
    tick(); idle(); #1;
    n_chk++; if (err_unf !== 4'b0001 || send_val !== '0) begin
      n_fail++; $display("FAIL mid_unf: unf=%b sv=%b want 0001/0000", err_unf, send_val); end
  endtask

  initial begin
    idle(); send_rdy = '0; reset = 1'b1;
    test_reset();
    test_write();
    test_overflow();
    test_read();
    test_same_cycle();
    test_independent();
    test_parity();
    test_bad_addr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
